// File: rtl/fetch_pkg.sv
// Shared widths and the fetch-entry type for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF   = 16;
  localparam int unsigned INST_W_DEF   = 16;
  localparam int unsigned FQ_DEPTH_DEF = 4;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [INST_W_DEF-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO prefetch queue with push, pop, synchronous flush, count and head outputs.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_valid = (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: fetch PC, 1-cycle imem read tracking, redirect/kill and prefetch queue.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       INST_W   = INST_W_DEF,
  parameter int unsigned       FQ_DEPTH = FQ_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      redirect_valid,
  input  logic [ADDR_W-1:0]         redirect_pc,
  output logic                      imem_rd_en,
  output logic [ADDR_W-1:0]         imem_addr,
  input  logic [INST_W-1:0]         imem_rd_data,
  output logic                      inst_valid,
  output logic [INST_W-1:0]         inst,
  output logic [ADDR_W-1:0]         inst_pc,
  input  logic                      inst_ready,
  output logic [$clog2(FQ_DEPTH):0] fq_count
);

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned OW = CW + 1;
  localparam int unsigned EW = ADDR_W + INST_W;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;

  logic              w_q_valid;
  logic [EW-1:0]     w_head;
  logic              w_pop;
  logic              w_push;
  logic [OW-1:0]     w_occupancy;

  // A redirect hides the head, so a same-cycle pop never reaches the queue.
  assign inst_valid = w_q_valid && !redirect_valid;
  assign inst_pc    = w_head[EW-1 -: ADDR_W];
  assign inst       = w_head[INST_W-1:0];
  assign w_pop      = inst_valid && inst_ready;

  // Reserve a slot for every outstanding read so the queue can never overflow.
  assign w_occupancy = {1'b0, fq_count} + OW'(r_inflight) - OW'(w_pop);
  assign imem_rd_en  = rst_n && !redirect_valid && (w_occupancy < OW'(FQ_DEPTH));
  assign imem_addr   = r_fetch_pc;

  // The only read that can land during a redirect is the one already in flight.
  assign w_push = r_inflight && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= imem_rd_en;
      if (imem_rd_en) r_inflight_pc <= r_fetch_pc;
      if (redirect_valid)  r_fetch_pc <= redirect_pc;
      else if (imem_rd_en) r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (EW)
  ) u_fetch_queue (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_wdata ({r_inflight_pc, imem_rd_data}),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_valid (w_q_valid),
    .o_head  (w_head),
    .o_count (fq_count)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: expected {pc, inst} pairs queued up front, checked on each accepted handoff.
module tb_inst_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned AW    = ADDR_W_DEF;
  localparam int unsigned IW    = INST_W_DEF;
  localparam int unsigned DEPTH = FQ_DEPTH_DEF;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          imem_rd_en;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rd_data;
  logic          inst_valid;
  logic [IW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_ready;
  logic [CW-1:0] fq_count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  fetch_entry_t sb[$];

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .ADDR_W   (AW),
    .INST_W   (IW),
    .FQ_DEPTH (DEPTH),
    .RESET_PC ('0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rd_data   (imem_rd_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .fq_count       (fq_count)
  );

  // Instruction memory: content is addr ^ 0xA5A5, one cycle read latency.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rd_data <= imem_addr ^ 16'hA5A5;
  end

  task automatic expect_pc(input logic [AW-1:0] pc);
    fetch_entry_t e;
    e.pc   = pc;
    e.inst = pc ^ 16'hA5A5;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    n_tests++; if (fq_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fq_count); end
    n_tests++; if (imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", imem_rd_en); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    fetch_entry_t e;
    inst_ready = 1'b1;
    for (int i = 0; i < 20; i++) expect_pc(AW'(i));
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_tests++; if (imem_rd_en !== 1'b1) begin n_fail++; $display("FAIL startup_rd_en: got %b want 1", imem_rd_en); end
        n_tests++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL startup_addr: got %h want 0000", imem_addr); end
      end
      n_tests++;
      if (inst_valid !== (c >= 2)) begin n_fail++; $display("FAIL stream_valid c%0d: got %b want %b", c, inst_valid, c >= 2); end
      if (inst_valid && inst_ready) begin
        n_tests++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL stream_pop: got pc %h want nothing", inst_pc); end
        else begin
          e = sb.pop_front();
          if (inst_pc !== e.pc || inst !== e.inst) begin
            n_fail++; $display("FAIL stream_pop: got pc %h inst %h want pc %h inst %h", inst_pc, inst, e.pc, e.inst);
          end
        end
      end
      step();
    end
    n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL stream_left: %0d entries not seen, want 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    fetch_entry_t e;
    rst_n = 1'b0; inst_ready = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        n_tests++;
        if (inst_valid !== 1'b1 || inst_pc !== 16'h0000) begin
          n_fail++; $display("FAIL hold_head c%0d: got valid %b pc %h want valid 1 pc 0000", c, inst_valid, inst_pc);
        end
      end
      if (c == 9) begin
        n_tests++; if (fq_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_count: got %0d want %0d", fq_count, DEPTH); end
        n_tests++; if (imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL full_rd_en: got %b want 0", imem_rd_en); end
      end
      step();
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 16; i++) expect_pc(AW'(i));
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      n_tests++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid c%0d: got %b want 1", c, inst_valid); end
      if (inst_valid && inst_ready) begin
        n_tests++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL drain_pop: got pc %h want nothing", inst_pc); end
        else begin
          e = sb.pop_front();
          if (inst_pc !== e.pc || inst !== e.inst) begin
            n_fail++; $display("FAIL drain_pop: got pc %h inst %h want pc %h inst %h", inst_pc, inst, e.pc, e.inst);
          end
        end
      end
      step();
    end
    n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL drain_left: %0d entries not seen, want 0", sb.size()); end
  endtask

  task automatic test_redirect();
    fetch_entry_t e;
    for (int i = 16; i < 20; i++) expect_pc(AW'(i));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        n_tests++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL pre_redir_pop: got pc %h want nothing", inst_pc); end
        else begin
          e = sb.pop_front();
          if (inst_pc !== e.pc || inst !== e.inst) begin
            n_fail++; $display("FAIL pre_redir_pop: got pc %h inst %h want pc %h inst %h", inst_pc, inst, e.pc, e.inst);
          end
        end
      end
      step();
    end
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    @(negedge clk);
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid_n: got %b want 0", inst_valid); end
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 6; i++) expect_pc(AW'(16'h0100 + i));
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_tests++; if (imem_rd_en !== 1'b1 || imem_addr !== 16'h0100) begin
          n_fail++; $display("FAIL redir_issue: got rd_en %b addr %h want rd_en 1 addr 0100", imem_rd_en, imem_addr);
        end
        n_tests++; if (fq_count !== '0) begin n_fail++; $display("FAIL redir_flush: got %0d want 0", fq_count); end
      end
      if (c == 3) begin
        n_tests++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL redir_latency: got valid %b want 1", inst_valid); end
      end
      if (inst_valid && inst_ready) begin
        n_tests++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL redir_pop: got pc %h want nothing", inst_pc); end
        else begin
          e = sb.pop_front();
          if (inst_pc !== e.pc || inst !== e.inst) begin
            n_fail++; $display("FAIL redir_pop: got pc %h inst %h want pc %h inst %h", inst_pc, inst, e.pc, e.inst);
          end
        end
      end
      step();
    end
    n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL redir_left: %0d entries not seen, want 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    fetch_entry_t e;
    inst_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_tests++;
      if (inst_valid !== 1'b1 || inst_pc !== 16'h0106) begin
        n_fail++; $display("FAIL b2b_hold c%0d: got valid %b pc %h want valid 1 pc 0106", c, inst_valid, inst_pc);
      end
      step();
    end
    redirect_valid = 1'b1; redirect_pc = 16'h0200; inst_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (fq_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL b2b_full: got %0d want %0d", fq_count, DEPTH); end
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_1: got %b want 0", inst_valid); end
    step();
    redirect_pc = 16'h0300;
    @(negedge clk);
    n_tests++; if (fq_count !== '0) begin n_fail++; $display("FAIL b2b_flush: got %0d want 0", fq_count); end
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_2: got %b want 0", inst_valid); end
    n_tests++; if (imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL b2b_rd_en: got %b want 0", imem_rd_en); end
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 8; i++) expect_pc(AW'(16'h0300 + i));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_tests++; if (imem_rd_en !== 1'b1 || imem_addr !== 16'h0300) begin
          n_fail++; $display("FAIL b2b_issue: got rd_en %b addr %h want rd_en 1 addr 0300", imem_rd_en, imem_addr);
        end
      end
      if (c == 2) begin
        n_tests++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_latency: got valid %b want 1", inst_valid); end
      end
      if (inst_valid && inst_ready) begin
        n_tests++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_pop: got pc %h want nothing", inst_pc); end
        else begin
          e = sb.pop_front();
          if (inst_pc !== e.pc || inst !== e.inst) begin
            n_fail++; $display("FAIL b2b_pop: got pc %h inst %h want pc %h inst %h", inst_pc, inst, e.pc, e.inst);
          end
        end
      end
      step();
    end
    n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_left: %0d entries not seen, want 0", sb.size()); end
  endtask

  task automatic test_wrap();
    fetch_entry_t e;
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    @(negedge clk);
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_valid_n: got %b want 0", inst_valid); end
    step();
    redirect_valid = 1'b0;
    expect_pc(16'hFFFE); expect_pc(16'hFFFF); expect_pc(16'h0000); expect_pc(16'h0001);
    for (int c = 1; c < 20 && sb.size() != 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_tests++; if (imem_addr !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_addr: got %h want fffe", imem_addr); end
      end
      if (inst_valid && inst_ready) begin
        n_tests++;
        e = sb.pop_front();
        if (inst_pc !== e.pc || inst !== e.inst) begin
          n_fail++; $display("FAIL wrap_pop: got pc %h inst %h want pc %h inst %h", inst_pc, inst, e.pc, e.inst);
        end
      end
      step();
    end
    n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL wrap_left: %0d entries not seen in budget, want 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    fetch_entry_t e;
    expect_pc(16'h0002); expect_pc(16'h0003);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        n_tests++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL pre_rst_pop: got pc %h want nothing", inst_pc); end
        else begin
          e = sb.pop_front();
          if (inst_pc !== e.pc || inst !== e.inst) begin
            n_fail++; $display("FAIL pre_rst_pop: got pc %h inst %h want pc %h inst %h", inst_pc, inst, e.pc, e.inst);
          end
        end
      end
      step();
    end
    n_tests++; if (fq_count === '0) begin n_fail++; $display("FAIL pre_rst_count: got 0 want nonzero"); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b want 0", inst_valid); end
    n_tests++; if (fq_count !== '0) begin n_fail++; $display("FAIL async_rst_count: got %0d want 0", fq_count); end
    n_tests++; if (imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL async_rst_rd_en: got %b want 0", imem_rd_en); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) expect_pc(AW'(i));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_tests++; if (imem_rd_en !== 1'b1 || imem_addr !== 16'h0000) begin
          n_fail++; $display("FAIL restart_issue: got rd_en %b addr %h want rd_en 1 addr 0000", imem_rd_en, imem_addr);
        end
      end
      n_tests++;
      if (inst_valid !== (c >= 2)) begin n_fail++; $display("FAIL restart_valid c%0d: got %b want %b", c, inst_valid, c >= 2); end
      if (inst_valid && inst_ready) begin
        n_tests++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL restart_pop: got pc %h want nothing", inst_pc); end
        else begin
          e = sb.pop_front();
          if (inst_pc !== e.pc || inst !== e.inst) begin
            n_fail++; $display("FAIL restart_pop: got pc %h inst %h want pc %h inst %h", inst_pc, inst, e.pc, e.inst);
          end
        end
      end
      step();
    end
    n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL restart_left: %0d entries not seen, want 0", sb.size()); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Parametrised instruction fetch front end. It holds its own fetch PC and reads a synchronous instruction memory with 1-cycle read latency. Fetched {pc, inst} pairs are buffered in a FIFO prefetch queue and handed to decode over a valid/ready handshake. Branch redirects flush the queue and discard any in-flight read. It sits between the instruction memory interface and the decode stage.

Parameters:
ADDR_W, 16, width of PC and memory address
INST_W, 16, instruction width
FQ_DEPTH, 4, prefetch queue entries; power of two, minimum 2
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
redirect_valid  in  1  branch taken this cycle; redirect fetch
redirect_pc  in  ADDR_W  branch target
imem_rd_en  out  1  memory read request this cycle
imem_addr  out  ADDR_W  read address; equals fetch_pc
imem_rd_data  in  INST_W  read data, valid the cycle after imem_rd_en
inst_valid  out  1  queue head valid to decode
inst  out  INST_W  head instruction
inst_pc  out  ADDR_W  head instruction PC
inst_ready  in  1  decode accepts the head this cycle
fq_count  out  $clog2(FQ_DEPTH)+1  current queue occupancy

Behaviour:
- Reset (async assert): fetch_pc=RESET_PC; queue empty; fq_count=0; inflight=0; inst_valid=0; imem_rd_en=0. Release is synchronised by the flop domain.
- Issue rule: imem_rd_en = !redirect_valid && (fq_count + inflight - pop) < FQ_DEPTH, where pop = inst_valid && inst_ready. On issue, fetch_pc <= fetch_pc+1, wrapping modulo 2^ADDR_W (0xFFFF -> 0x0000 at default width).
- inflight: a flop set to imem_rd_en. Its response is pushed at the end of the next cycle as {pc of that read, imem_rd_data}, unless it is killed.
- Pop: occurs when inst_valid && inst_ready. Push and pop in the same cycle are allowed, including when the queue is full.
- Full throughput: one instruction per cycle in steady state when inst_ready=1. The queue never overflows.
- Startup timing: first cycle after reset release has imem_rd_en=1 with addr=RESET_PC. Data arrives the next cycle. inst_valid=1 with inst_pc=RESET_PC two cycles after the first issue.
- Redirect at cycle N:
  - Queue flushed; fq_count=0 from N+1.
  - Any response arriving in N or N+1 from an earlier issue is dropped.
  - fetch_pc <= redirect_pc.
  - inst_valid is forced to 0 during N; a pop in cycle N is ignored.
  - N+1: imem_rd_en=1 with addr=redirect_pc.
  - N+3: inst_valid=1 with inst_pc=redirect_pc.
- Back-to-back redirects: the latest one wins. Earlier targets are never presented.
- Redirect while the queue is full or empty behaves identically.
- Redirect takes priority over push and pop in the same cycle.
- Holding: inst, inst_pc and inst_valid stay stable while inst_valid && !inst_ready.
- Reset mid-operation: all state returns to reset values immediately. Any data returning after reset is ignored because inflight is cleared.

Decomposition:
- Package fetch_pkg: ADDR_W/INST_W defaults and the fetch entry typedef {pc, inst}.
- Sub-module fetch_queue: synchronous FIFO with push, pop, synchronous flush, count, and head outputs, parametrised by depth and entry width.
- inst_fetch_unit itself holds the PC, inflight/kill tracking and issue logic.

Test Plan:
1. Reset release, memory holds inst=addr^0xA5A5, inst_ready=1 -> inst_valid at cycle 2 with pc 0,1,2,3,... every cycle, no gaps.
2. inst_ready=0 for 10 cycles -> fq_count saturates at 4, imem_rd_en drops, and holding inst_ready=0 keeps the head at pc 0. Releasing ready -> pcs 0..N in order with no loss or duplicate.
3. Steady stream, redirect_valid with redirect_pc=0x0100 at cycle N -> no instruction with the old pc after N, imem_addr=0x0100 at N+1, inst_pc=0x0100 at N+3.
4. Redirects to 0x0200 then 0x0300 on consecutive cycles, with queue full and inst_ready=1 during the redirect -> only the 0x0300 stream appears, and fq_count=0 the cycle after.
5. Redirect to 0xFFFE -> pcs 0xFFFE, 0xFFFF, 0x0000, 0x0001.
6. Assert rst_n low mid-stream for 1 cycle -> outputs are reset asynchronously (inst_valid=0, fq_count=0), and the fetch restarts at RESET_PC with the startup timing.
